// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : UART receive core. Oversamples RX_IN (Prescale clocks per
//               bit), deserializes LSB first, checks optional parity and the
//               stop bit, and strobes Data_Valid for one clock on good frames.
//               Optional build macro UART_RX_MAJORITY_VOTE_EN selects 2-of-3
//               majority sampling around mid-bit instead of a single sample.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  sample_q, sample_d;
    logic [5:0]            pre_q, pre_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;

    logic [5:0] w_pre_norm;
    logic [5:0] w_half;
    logic [5:0] w_dec_pt;
    logic       w_bit;
    logic       w_decide;
    logic       w_last;
    logic       w_par_exp;

    // Unsupported oversampling ratios fall back to 8
    assign w_pre_norm = (Prescale == 6'd16 || Prescale == 6'd32) ? Prescale : 6'd8;
    assign w_half     = {1'b0, pre_q[5:1]};
    assign w_last     = (edge_q == pre_q - 6'd1);
    assign w_decide   = (edge_q == w_dec_pt);
    assign w_par_exp  = (^shift_q) ^ par_typ_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic maj_a_q, maj_a_d;
    logic maj_b_q, maj_b_d;

    // Decision at the third sample: two earlier samples plus the live line
    assign w_dec_pt = w_half + 6'd1;
    assign w_bit    = (maj_a_q & maj_b_q) | (maj_a_q & RX_IN) | (maj_b_q & RX_IN);

    // Capture the two early samples of the vote window
    always_comb begin
        maj_a_d = maj_a_q;
        maj_b_d = maj_b_q;
        if (edge_q == w_half - 6'd1) maj_a_d = RX_IN;
        if (edge_q == w_half)        maj_b_d = RX_IN;
    end

    // Vote sample registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            maj_a_q <= 1'b1;
            maj_b_q <= 1'b1;
        end else begin
            maj_a_q <= maj_a_d;
            maj_b_q <= maj_b_d;
        end
    end
`else
    assign w_dec_pt = w_half;
    assign w_bit    = RX_IN;
`endif

    // Next-state, counter, datapath and flag logic
    always_comb begin
        state_d   = state_q;
        edge_d    = w_last ? 6'd0 : edge_q + 6'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        sample_d  = w_decide ? w_bit : sample_q;
        pre_d     = pre_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        pdata_d   = pdata_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        serr_d    = serr_q;

        case (state_q)
            S_IDLE: begin
                edge_d   = 6'd0;
                bit_d    = '0;
                sample_d = sample_q;
                if (!RX_IN) begin
                    // Detection cycle counts as edge 0 of the start bit
                    state_d   = S_START;
                    edge_d    = 6'd1;
                    pre_d     = w_pre_norm;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end
            end
            S_START: begin
                if (w_decide) begin
                    if (w_bit) begin
                        // Glitch: abandon quietly, flags untouched
                        state_d = S_IDLE;
                        edge_d  = 6'd0;
                    end else begin
                        perr_d = 1'b0;
                        serr_d = 1'b0;
                    end
                end else if (w_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    shift_d = {sample_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == C_LAST_BIT) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_last) begin
                    perr_d  = (sample_q != w_par_exp);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Register one clock early so the strobe lands on the last stop clock
                if (edge_q == pre_q - 6'd2) begin
                    serr_d = ~sample_q;
                    if (!perr_q && sample_q) begin
                        valid_d = 1'b1;
                        pdata_d = shift_q;
                    end
                end
                if (w_last) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                edge_d  = 6'd0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            edge_q    <= 6'd0;
            bit_q     <= '0;
            shift_q   <= '0;
            sample_q  <= 1'b1;
            pre_q     <= 6'd8;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            pdata_q   <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            sample_q  <= sample_d;
            pre_q     <= pre_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            pdata_q   <= pdata_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign Data_Valid = valid_q;
    assign Par_Err    = perr_q;
    assign Stp_Err    = serr_q;

endmodule
`default_nettype wire
